// File: rtl/clk_gen_pkg.sv
// Shared types and helpers for the clock-generator oscillator calibration logic.
package clk_gen_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETTLE,
      ST_SNAP,
      ST_MEASURE,
      ST_COMPARE,
      ST_DONE
   } clk_gen_cal_state_e;

   // Width of the shared settle/window down-counter.
   function automatic int cal_cnt_width(input int window, input int settle);
      int m;
      m = (window > settle) ? window : settle;
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/clk_gen_gray2bin.sv
// Combinational Gray-to-binary decoder: each binary bit is the XOR of all Gray bits at or above it.
module clk_gen_gray2bin #(
   parameter int width_p = 16
) (
   input  logic [width_p-1:0] gray_i,
   output logic [width_p-1:0] bin_o
);

   for (genvar gi = 0; gi < width_p; gi++) begin : g_bit
      assign bin_o[gi] = ^gray_i[width_p-1:gi];
   end

endmodule

// File: rtl/clk_gen_osc_cal_ctrl.sv
// SAR calibration of the ring-oscillator trim: measures oscillator edges per reference window
// and keeps each trim bit while the oscillator runs faster than the target.
module clk_gen_osc_cal_ctrl
   import clk_gen_pkg::*;
#(
   parameter int cnt_width_p  = 16,
   parameter int trim_width_p = 5,
   parameter int window_p     = 1024,
   parameter int settle_p     = 16
) (
   input  logic                    clk_i,
   input  logic                    reset_n_i,
   input  logic                    start_i,
   input  logic [cnt_width_p-1:0]  target_i,
   input  logic [cnt_width_p-1:0]  tol_i,
   input  logic [cnt_width_p-1:0]  osc_gray_i,
   output logic [trim_width_p-1:0] trim_o,
   output logic                    busy_o,
   output logic                    done_o,
   output logic                    locked_o,
   output logic                    fail_o,
   output logic [cnt_width_p-1:0]  meas_o
);

   localparam int CW = cal_cnt_width(window_p, settle_p);
   localparam int BW = (trim_width_p > 1) ? $clog2(trim_width_p) : 1;
   localparam logic [CW-1:0] SETTLE_LD = CW'(settle_p - 1);
   localparam logic [CW-1:0] WINDOW_LD = CW'(window_p - 1);

   clk_gen_cal_state_e r_state, w_state_next;
   logic [CW-1:0]           r_cnt, w_cnt_next;
   logic [BW-1:0]           r_bit, w_bit_next;
   logic                    r_verify, w_verify_next;
   logic [trim_width_p-1:0] r_trim, w_trim_next;
   logic [cnt_width_p-1:0]  r_target, w_target_next;
   logic [cnt_width_p-1:0]  r_tol, w_tol_next;
   logic [cnt_width_p-1:0]  r_start_cnt, w_start_cnt_next;
   logic [cnt_width_p-1:0]  r_meas, w_meas_next;
   logic                    r_locked, w_locked_next;
   logic                    r_fail, w_fail_next;

   logic [cnt_width_p-1:0]  w_bin;
   logic [cnt_width_p-1:0]  w_delta;
   logic [cnt_width_p-1:0]  w_absdiff;
   logic [trim_width_p-1:0] w_mask;
   logic                    w_keep;

   clk_gen_gray2bin #(
      .width_p (cnt_width_p)
   ) u_gray2bin (
      .gray_i (osc_gray_i),
      .bin_o  (w_bin)
   );

   // Modular subtraction makes counter wrap-around within a window transparent.
   assign w_delta   = w_bin - r_start_cnt;
   assign w_absdiff = (w_delta >= r_target) ? (w_delta - r_target) : (r_target - w_delta);
   assign w_keep    = (w_delta > r_target);
   assign w_mask    = trim_width_p'(1) << r_bit;

   always_comb begin
      w_state_next     = r_state;
      w_cnt_next       = r_cnt;
      w_bit_next       = r_bit;
      w_verify_next    = r_verify;
      w_trim_next      = r_trim;
      w_target_next    = r_target;
      w_tol_next       = r_tol;
      w_start_cnt_next = r_start_cnt;
      w_meas_next      = r_meas;
      w_locked_next    = r_locked;
      w_fail_next      = r_fail;
      case (r_state)
         ST_IDLE: begin
            if (start_i) begin
               w_target_next = target_i;
               w_tol_next    = tol_i;
               w_locked_next = 1'b0;
               w_fail_next   = 1'b0;
               w_trim_next   = trim_width_p'(1) << (trim_width_p - 1);
               w_bit_next    = BW'(trim_width_p - 1);
               w_verify_next = 1'b0;
               w_cnt_next    = SETTLE_LD;
               w_state_next  = ST_SETTLE;
            end
         end
         ST_SETTLE: begin
            if (r_cnt == '0) w_state_next = ST_SNAP;
            else             w_cnt_next   = r_cnt - 1'b1;
         end
         ST_SNAP: begin
            w_start_cnt_next = w_bin;
            w_cnt_next       = WINDOW_LD;
            w_state_next     = ST_MEASURE;
         end
         ST_MEASURE: begin
            if (r_cnt == '0) w_state_next = ST_COMPARE;
            else             w_cnt_next   = r_cnt - 1'b1;
         end
         ST_COMPARE: begin
            w_meas_next = w_delta;
            if (r_verify) begin
               w_locked_next = (w_absdiff <= r_tol);
               w_fail_next   = !(w_absdiff <= r_tol);
               w_state_next  = ST_DONE;
            end else begin
               // Too fast keeps the added delay; bit 0 decided means one more pass to verify.
               w_trim_next = w_keep ? r_trim : (r_trim & ~w_mask);
               if (r_bit != '0) begin
                  w_trim_next = w_trim_next | (w_mask >> 1);
                  w_bit_next  = r_bit - BW'(1);
               end else begin
                  w_verify_next = 1'b1;
               end
               w_cnt_next   = SETTLE_LD;
               w_state_next = ST_SETTLE;
            end
         end
         ST_DONE: begin
            w_state_next = ST_IDLE;
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         r_state     <= ST_IDLE;
         r_cnt       <= '0;
         r_bit       <= '0;
         r_verify    <= 1'b0;
         r_trim      <= '0;
         r_target    <= '0;
         r_tol       <= '0;
         r_start_cnt <= '0;
         r_meas      <= '0;
         r_locked    <= 1'b0;
         r_fail      <= 1'b0;
      end else begin
         r_state     <= w_state_next;
         r_cnt       <= w_cnt_next;
         r_bit       <= w_bit_next;
         r_verify    <= w_verify_next;
         r_trim      <= w_trim_next;
         r_target    <= w_target_next;
         r_tol       <= w_tol_next;
         r_start_cnt <= w_start_cnt_next;
         r_meas      <= w_meas_next;
         r_locked    <= w_locked_next;
         r_fail      <= w_fail_next;
      end
   end

   assign trim_o   = r_trim;
   assign busy_o   = (r_state != ST_IDLE);
   assign done_o   = (r_state == ST_DONE);
   assign locked_o = r_locked;
   assign fail_o   = r_fail;
   assign meas_o   = r_meas;

endmodule

// File: tb/tb_clk_gen_osc_cal_ctrl.sv
// Bench for clk_gen_osc_cal_ctrl: trim-dependent oscillator model, scoreboard of expected
// calibration results, and a negedge monitor that checks every done pulse.
module tb_clk_gen_osc_cal_ctrl;

   localparam int W   = 16;
   localparam int TW  = 4;
   localparam int WIN = 64;
   localparam int SET = 4;
   localparam int M   = SET + 1 + WIN + 1;
   localparam int CAL_CYCLES = (TW + 1) * M;

   typedef struct {
      int          target;
      int          tol;
      logic [TW-1:0] trim;
      logic [W-1:0]  meas;
      bit          locked;
      bit          fail;
      longint      done_cyc;
   } exp_t;

   logic          clk = 1'b0;
   logic          reset_n_i = 1'b0;
   logic          start_i = 1'b0;
   logic [W-1:0]  target_i = '0;
   logic [W-1:0]  tol_i = '0;
   logic [W-1:0]  osc_gray_i;
   logic [TW-1:0] trim_o;
   logic          busy_o, done_o, locked_o, fail_o;
   logic [W-1:0]  meas_o;

   clk_gen_osc_cal_ctrl #(
      .cnt_width_p  (W),
      .trim_width_p (TW),
      .window_p     (WIN),
      .settle_p     (SET)
   ) dut (
      .clk_i      (clk),
      .reset_n_i  (reset_n_i),
      .start_i    (start_i),
      .target_i   (target_i),
      .tol_i      (tol_i),
      .osc_gray_i (osc_gray_i),
      .trim_o     (trim_o),
      .busy_o     (busy_o),
      .done_o     (done_o),
      .locked_o   (locked_o),
      .fail_o     (fail_o),
      .meas_o     (meas_o)
   );

   always #5 clk = ~clk;

   longint cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Oscillator: a SNAP-to-COMPARE interval spans WIN+1 reference edges, so the
   // accumulator advances rate per edge in units of 1/(WIN+1) edge, making every
   // measurement see exactly (1000 - 40*trim) edges.
   longint       osc_acc = 0;
   bit           osc_load_req = 0;
   logic [W-1:0] osc_load_val = '0;
   logic [W-1:0] osc_bin;

   always @(posedge clk) begin
      if (osc_load_req) osc_acc <= longint'(osc_load_val) * (WIN + 1);
      else              osc_acc <= osc_acc + (1000 - 40 * longint'(trim_o));
   end
   assign osc_bin    = W'(osc_acc / (WIN + 1));
   assign osc_gray_i = osc_bin ^ (osc_bin >> 1);

   function automatic int osc_rate(input int t);
      return 1000 - 40 * t;
   endfunction

   // Reference: binary search over trim codes using the oscillator's edge rate directly.
   function automatic exp_t model(input int target, input int tol);
      exp_t e;
      int   t, trial, d, diff;
      t = 0;
      for (int b = TW - 1; b >= 0; b--) begin
         trial = t | (1 << b);
         if (osc_rate(trial) > target) t = trial;
      end
      d    = osc_rate(t);
      diff = (d > target) ? d - target : target - d;
      e.target   = target;
      e.tol      = tol;
      e.trim     = TW'(t);
      e.meas     = W'(d);
      e.locked   = (diff <= tol);
      e.fail     = !(diff <= tol);
      e.done_cyc = 0;
      return e;
   endfunction

   exp_t sb_q[$];

   // Requests from the stimulus process; only the monitor touches the counters.
   int rst_req = 0;
   int start_req = 0;
   int to_req = 0;

   int errors = 0;
   int checks = 0;
   int rst_seen = 0, start_seen = 0, to_seen = 0;
   bit busy_chk = 0;

   always @(negedge clk) begin
      exp_t e;
      if (busy_chk) begin
         busy_chk = 0;
         checks++;
         if (busy_o !== 1'b0) begin
            errors++;
            $display("FAIL busy_fall: busy_o=%0b required 0", busy_o);
         end
      end
      if (rst_req != rst_seen) begin
         rst_seen = rst_req;
         checks++;
         if ({trim_o, busy_o, done_o, locked_o, fail_o, meas_o} !== '0) begin
            errors++;
            $display("FAIL reset_values: trim=%0d busy=%0b done=%0b locked=%0b fail=%0b meas=%0d required all 0",
                     trim_o, busy_o, done_o, locked_o, fail_o, meas_o);
         end
      end
      if (start_req != start_seen) begin
         start_seen = start_req;
         checks++;
         if (busy_o !== 1'b1 || trim_o !== TW'(1 << (TW - 1))) begin
            errors++;
            $display("FAIL start_accept: busy=%0b trim=%0d required busy=1 trim=%0d",
                     busy_o, trim_o, 1 << (TW - 1));
         end
      end
      if (to_req != to_seen) begin
         to_seen = to_req;
         checks++;
         errors++;
         $display("FAIL done_timeout: no done_o within %0d cycles required one", CAL_CYCLES + 50);
      end
      if (reset_n_i && done_o === 1'b1) begin
         if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL extra_done: done_o=1 at cycle %0d required no pulse", cyc);
         end else begin
            e = sb_q.pop_front();
            $display("cal target=%0d tol=%0d -> trim=%0d meas=%0d locked=%0b fail=%0b cycle=%0d",
                     e.target, e.tol, trim_o, meas_o, locked_o, fail_o, cyc);
            checks++;
            if (trim_o !== e.trim) begin
               errors++;
               $display("FAIL trim: got %0d required %0d", trim_o, e.trim);
            end
            checks++;
            if (meas_o !== e.meas) begin
               errors++;
               $display("FAIL meas: got %0d required %0d", meas_o, e.meas);
            end
            checks++;
            if (locked_o !== e.locked || fail_o !== e.fail) begin
               errors++;
               $display("FAIL lock_flags: got locked=%0b fail=%0b required locked=%0b fail=%0b",
                        locked_o, fail_o, e.locked, e.fail);
            end
            checks++;
            if (cyc != e.done_cyc) begin
               errors++;
               $display("FAIL done_latency: got cycle %0d required %0d", cyc, e.done_cyc);
            end
            busy_chk = 1;
         end
      end
   end

   task automatic preload(input logic [W-1:0] val);
      @(negedge clk);
      osc_load_val = val;
      osc_load_req = 1;
      @(negedge clk);
      osc_load_req = 0;
   endtask

   // One calibration; push_exp=0 is used when the run will be cut short by reset.
   task automatic run_cal(input int target, input int tol, input bit push_exp,
                          input bit ign_measure, input bit ign_done);
      exp_t e;
      int   n;
      bit   seen;
      @(negedge clk);
      target_i = W'(target);
      tol_i    = W'(tol);
      start_i  = 1;
      e = model(target, tol);
      e.done_cyc = cyc + 1 + CAL_CYCLES;
      if (push_exp) sb_q.push_back(e);
      @(negedge clk);
      start_i  = 0;
      start_req++;
      target_i = W'($urandom);
      tol_i    = W'($urandom);
      if (!push_exp) return;
      if (ign_measure) begin
         repeat (40) @(negedge clk);
         start_i = 1;
         @(negedge clk);
         start_i = 0;
      end
      n = 0;
      seen = 0;
      while (!seen && n < CAL_CYCLES + 50) begin
         @(negedge clk);
         n++;
         if (done_o === 1'b1) seen = 1;
      end
      if (!seen) to_req++;
      if (seen && ign_done) begin
         start_i = 1;
         @(negedge clk);
         start_i = 0;
         repeat (CAL_CYCLES + 20) @(negedge clk);
      end
      repeat (3) @(negedge clk);
   endtask

   initial begin
      reset_n_i = 0;
      repeat (3) @(negedge clk);
      rst_req++;
      repeat (3) @(negedge clk);
      reset_n_i = 1;
      repeat (2) @(negedge clk);

      run_cal(500, 20, 1, 0, 0);          // nominal lock
      run_cal(500, 4, 1, 0, 0);           // same search, out of tolerance
      preload(16'hFFF0);
      run_cal(500, 20, 1, 0, 0);          // counter wraps early
      preload(16'hFED0);
      run_cal(500, 20, 1, 0, 0);          // counter wraps inside a window
      run_cal(0, 0, 1, 0, 0);             // saturate at max trim
      run_cal(2000, 0, 1, 0, 0);          // saturate at zero trim
      run_cal(520, 0, 1, 0, 0);           // equality clears the bit
      run_cal(500, 20, 1, 1, 1);          // ignored starts

      run_cal(500, 20, 0, 0, 0);          // reset during the second MEASURE
      repeat (M + 30) @(negedge clk);
      reset_n_i = 0;
      @(negedge clk);
      rst_req++;
      repeat (3) @(negedge clk);
      reset_n_i = 1;
      run_cal(500, 20, 1, 0, 0);

      for (int i = 0; i < 8; i++) begin
         preload(W'($urandom));
         run_cal(int'($urandom_range(300, 1100)), int'($urandom_range(0, 60)), 1, 0, 0);
      end

      repeat (5) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/clk_gen_osc_cal_ctrl.md
# clk_gen_osc_cal_ctrl

Calibration controller for the clock generator's inverter-chain ring oscillator. It runs a successive-approximation (SAR) search over the oscillator delay trim code, measuring oscillator edges against a fixed window of reference-clock cycles. It stops at the trim whose edge count is closest from above to a programmed target, then reports lock or failure. It sits beside the oscillator in the clock-generator block, drives the oscillator's trim input, and samples the oscillator's free-running Gray-coded edge counter, which is already synchronized into `clk_i`.

## Interface
Parameters:
- `cnt_width_p`, 16: width of oscillator edge counter and of measured delta.
- `trim_width_p`, 5: width of trim code (SAR iterations).
- `window_p`, 1024: measurement window in `clk_i` cycles, ≥2.
- `settle_p`, 16: cycles waited after every trim change, ≥1.

Ports:
- `clk_i`, in, 1: reference clock; the only clock.
- `reset_n_i`, in, 1: synchronous active-low reset.
- `start_i`, in, 1: start calibration; sampled only in IDLE.
- `target_i`, in, `cnt_width_p`: desired edge count per window; sampled when the start is accepted.
- `tol_i`, in, `cnt_width_p`: lock tolerance; sampled when the start is accepted.
- `osc_gray_i`, in, `cnt_width_p`: synchronized Gray-coded oscillator edge count.
- `trim_o`, out, `trim_width_p`: oscillator trim. Larger value means more delay and fewer edges.
- `busy_o`, out, 1: calibration in progress.
- `done_o`, out, 1: one-cycle pulse when calibration ends.
- `locked_o`, out, 1: level; last calibration ended within tolerance.
- `fail_o`, out, 1: level; last calibration ended outside tolerance.
- `meas_o`, out, `cnt_width_p`: delta from the most recent completed measurement.

## Operation
- FSM states: IDLE, SETTLE, SNAP, MEASURE, COMPARE, DONE.
- **IDLE**
  - On `start_i`=1: latch `target_i`/`tol_i`, clear `locked_o`/`fail_o`, set `trim_o` to MSB-only, set bit index to MSB, go to SETTLE.
- **SETTLE**
  - Count `settle_p` cycles, then go to SNAP.
- **SNAP**
  - Register the decoded binary count as `start_cnt`, then go to MEASURE.
- **MEASURE**
  - Count `window_p` cycles, then go to COMPARE.
- **COMPARE**
  - `delta = cur_cnt - start_cnt`, modulo 2^`cnt_width_p`, so counter wrap-around is transparent. `delta` is written to `meas_o`.
  - Search phase: if `delta > target`, keep the current bit (the oscillator is too fast). Otherwise clear it.
    - If bit index > 0: decrement the index, set the next lower bit in `trim_o`, go to SETTLE.
    - If bit index = 0: the trim is final. Run one verification measurement (SETTLE→SNAP→MEASURE→COMPARE) with the unchanged trim.
  - Verification phase: `locked_o = (|delta - target| ≤ tol)`, `fail_o` = the inverse. Go to DONE.
- **DONE**
  - Assert `done_o` for one cycle, go to IDLE.
  - `trim_o` holds its final value until the next start or reset.
- `busy_o` = 1 in every state except IDLE.
- `start_i` outside IDLE is ignored.
- `target_i`/`tol_i` changes while busy have no effect.
- Gray→binary decode is combinational on `osc_gray_i`, sampled by the SNAP and COMPARE registers.
- Comparisons are unsigned at `cnt_width_p` bits. The absolute difference is computed at `cnt_width_p` bits with no overflow (operands are in range).

## Timing
- **Reset values:** `trim_o`=0, `busy_o`=0, `done_o`=0, `locked_o`=0, `fail_o`=0, `meas_o`=0. State = IDLE; all counters = 0.
- **Reset mid-calibration:** returns to the reset values at the next edge. There is no `done_o` pulse.
- **Measurement slot length** M = `settle_p` + 1 + `window_p` + 1 cycles.
- **Start acceptance:** `start_i` high at edge N in IDLE gives `busy_o`=1 and the new `trim_o` from cycle N+1.
- **Completion:** `done_o` is high in cycle N+1+(`trim_width_p`+1)·M. `busy_o` falls in the following cycle.
- **Output update times:**
  - `trim_o` changes only on the COMPARE→SETTLE transition and at start.
  - `meas_o` updates in the cycle after each COMPARE.
  - `locked_o`/`fail_o` update together with `done_o` and hold until the next accepted start.
- **Start coincident with DONE:** ignored; a new start is accepted only in IDLE.

## Structure
- Shared package `clk_gen_pkg`:
  - FSM state enum `clk_gen_cal_state_e`.
  - A function computing the window-counter width (`$clog2` of `max(window_p, settle_p)+1`).
- Sub-module `clk_gen_gray2bin` (parameter `width_p`, pure combinational XOR-prefix decode), instantiated once on `osc_gray_i`.
- The single window/settle down-counter is shared between SETTLE and MEASURE.

## Test plan
Bench model: oscillator Gray counter advancing by `(1000 - 40·trim)` per `window_p`=64 cycles, with `trim_width_p`=4, `settle_p`=4.
- **Nominal lock.** Start with target=500, tol=20.
  - Search sequence: trim 8 (680, keep) → 12 (520, keep) → 14 (440, clear) → 13 (480, clear).
  - Final `trim_o`=12, `meas_o`=520, `locked_o`=1, `fail_o`=0.
  - `done_o` exactly 1+5·70 cycles after start.
- **Fail.** Same stimulus with tol=4 → `trim_o`=12, `fail_o`=1, `locked_o`=0.
- **Wrap-around.** Counter preloaded to 0xFFF0 before start → identical deltas and results to the nominal lock case.
- **Saturation.** target=0 → `trim_o`=15. target=2000 → `trim_o`=0, `fail_o`=1.
- **Ignored start.** `start_i` pulses during MEASURE and in the DONE cycle → no restart; exactly one `done_o`.
- **Reset mid-calibration.** `reset_n_i` low during the second MEASURE → next cycle all outputs at reset values. A subsequent start completes normally.
